// File: rtl/fp_divsqrt_if.sv
// Issue/writeback bundle between the integer unit and fp_divsqrt_unit.
// master: integer-unit side (drives the operation); slave: the divide unit.
interface fp_divsqrt_if;
  logic        start;
  logic        fsqrt;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  fd;
  logic        busy;
  logic        done;
  logic [4:0]  rn;
  logic [31:0] result;

  modport master (output start, fsqrt, a, b, fd,
                  input  busy, done, rn, result);
  modport slave  (input  start, fsqrt, a, b, fd,
                  output busy, done, rn, result);
endinterface

// File: rtl/fp_divsqrt_unit.sv
// Iterative IEEE-754 single-precision divider (restoring, one quotient bit
// per cycle, round-to-nearest-even, denormals flushed to signed zero).
// Optional square root selected by fsqrt is built only when the macro
// FP_DIVSQRT_FSQRT_EN is defined; otherwise fsqrt returns the default qNaN
// after the same fixed latency.
// The datapath assumes ITER = 26 (24 significand bits + guard + round).
module fp_divsqrt_unit #(
  parameter int ITER = 26
) (
  input  logic        clk,
  input  logic        clrn,
  fp_divsqrt_if.slave bus
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_ROUND, S_DONE} state_t;

  state_t            state, state_nx;
  logic [4:0]        cnt;
  logic              busy, accept;
  logic              done_r;
  logic [31:0]       result_r;
  logic [4:0]        rn_r;

  // Operation context captured at start.
  logic              op_sqrt, sign, special;
  logic [31:0]       special_val;
  logic signed [9:0] exp_r;
  logic [4:0]        rn_lat;
  logic [23:0]       mb;
  logic [25:0]       q;
  logic [27:0]       rem;
  logic [31:0]       res_r;
`ifdef FP_DIVSQRT_FSQRT_EN
  logic [51:0]       rad;
  logic [51:0]       rad_in;
  logic signed [9:0] e_unb;
  logic [29:0]       sq_cat, sq_trial;
  logic              sq_ge;
`endif

  // Unpack/classify signals.
  logic [7:0]        ea, eb;
  logic [23:0]       ma, mb_in;
  logic              za, zb, ia, ib, na, nb, lt;
  logic              sign_in, sp_in;
  logic [31:0]       sp_val_in;
  logic signed [9:0] exp_in;
  logic [27:0]       rem_in;

  // Iteration/rounding signals.
  logic              div_ge;
  logic [25:0]       q_nx;
  logic [27:0]       rem_nx;
  logic              up;
  logic [24:0]       mr;
  logic [22:0]       mant;
  logic signed [9:0] e_rnd;
  logic [31:0]       round_val;

  assign accept     = bus.start && (state == S_IDLE) && !done_r;
  assign bus.busy   = busy;
  assign bus.done   = done_r;
  assign bus.rn     = rn_r;
  assign bus.result = result_r;

  // State register and iteration counter.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clrn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == S_ITER) ? cnt + 5'd1 : '0;
    end
  end

  // Next-state and busy decode.
  // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE) || done_r;
    case (state)
      S_IDLE:  if (accept) state_nx = S_ITER;
      S_ITER:  if (cnt == 5'(ITER - 1)) state_nx = S_ROUND;
      S_ROUND: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand unpack, special-case classification and initial exponent/remainder.
  always_comb begin
    ea        = bus.a[30:23];
    eb        = bus.b[30:23];
    ma        = {1'b1, bus.a[22:0]};
    mb_in     = {1'b1, bus.b[22:0]};
    za        = (ea == 8'h00);
    zb        = (eb == 8'h00);
    ia        = (ea == 8'hFF) && (bus.a[22:0] == 23'd0);
    ib        = (eb == 8'hFF) && (bus.b[22:0] == 23'd0);
    na        = (ea == 8'hFF) && (bus.a[22:0] != 23'd0);
    nb        = (eb == 8'hFF) && (bus.b[22:0] != 23'd0);
    lt        = ma < mb_in;
    sign_in   = bus.a[31] ^ bus.b[31];
    exp_in    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127 - (lt ? 10'sd1 : 10'sd0);
    rem_in    = lt ? {3'b000, ma, 1'b0} : {4'b0000, ma};
    sp_in     = 1'b1;
    sp_val_in = QNAN;
`ifdef FP_DIVSQRT_FSQRT_EN
    e_unb     = $signed({2'b00, ea}) - 10'sd127;
    rad_in    = '0;
`endif
    if (bus.fsqrt) begin
`ifdef FP_DIVSQRT_FSQRT_EN
      sign_in = 1'b0;
      exp_in  = (e_unb >>> 1) + 10'sd127;
      rem_in  = '0;
      // Odd unbiased exponent (even biased) folds a factor of 2 into the radicand.
      rad_in  = ea[0] ? {1'b0, ma, 27'd0} : {ma, 1'b0, 27'd0};
      if (na || (bus.a[31] && !za)) sp_val_in = QNAN;
      else if (za)                  sp_val_in = {bus.a[31], 31'd0};
      else if (ia)                  sp_val_in = 32'h7F80_0000;
      else                          sp_in     = 1'b0;
`endif
    end else begin
      if (na || nb || (za && zb) || (ia && ib)) sp_val_in = QNAN;
      else if (ia || zb)                        sp_val_in = {sign_in, 8'hFF, 23'd0};
      else if (ib || za)                        sp_val_in = {sign_in, 31'd0};
      else                                      sp_in     = 1'b0;
    end
  end

  // One restoring step: quotient bit for divide, root bit for square root.
  always_comb begin
    div_ge = rem >= {4'b0000, mb};
    q_nx   = {q[24:0], div_ge};
    rem_nx = (div_ge ? rem - {4'b0000, mb} : rem) << 1;
`ifdef FP_DIVSQRT_FSQRT_EN
    sq_cat   = {rem, rad[51:50]};
    sq_trial = {2'b00, q, 2'b01};
    sq_ge    = sq_cat >= sq_trial;
    if (op_sqrt) begin
      q_nx   = {q[24:0], sq_ge};
      rem_nx = sq_ge ? sq_cat[27:0] - sq_trial[27:0] : sq_cat[27:0];
    end
`endif
  end

  // Round-to-nearest-even, carry renormalise, overflow/underflow, specials.
  always_comb begin
    up = q[1] & (q[0] | (rem != 28'd0) | q[2]);
    mr = {1'b0, q[25:2]} + {24'd0, up};
    if (mr[24]) begin
      mant  = mr[23:1];
      e_rnd = exp_r + 10'sd1;
    end else begin
      mant  = mr[22:0];
      e_rnd = exp_r;
    end
    if (special)                round_val = special_val;
    else if (e_rnd >= 10'sd255) round_val = {sign, 8'hFF, 23'd0};
    else if (e_rnd <= 10'sd0)   round_val = {sign, 31'd0};
    else                        round_val = {sign, e_rnd[7:0], mant};
  end

  // Operation datapath: capture at start, iterate, hold the rounded result.
  // NOTE: datapath registers carry no reset; they are always loaded before being read.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: if (accept) begin
        op_sqrt     <= bus.fsqrt;
        rn_lat      <= bus.fd;
        sign        <= sign_in;
        special     <= sp_in;
        special_val <= sp_val_in;
        exp_r       <= exp_in;
        mb          <= mb_in;
        rem         <= rem_in;
        q           <= '0;
`ifdef FP_DIVSQRT_FSQRT_EN
        rad         <= rad_in;
`endif
      end
      S_ITER: begin
        q   <= q_nx;
        rem <= rem_nx;
`ifdef FP_DIVSQRT_FSQRT_EN
        rad <= rad << 2;
`endif
      end
      S_ROUND: res_r <= round_val;
      default: ;
    endcase
  end

  // Writeback outputs: one-cycle done pulse, result/rn held until the next op.
  always_ff @(posedge clk) begin
    if (clrn) begin
      done_r   <= 1'b0;
      result_r <= '0;
      rn_r     <= '0;
    end else begin
      done_r <= (state == S_DONE);
      if (state == S_DONE) begin
        result_r <= res_r;
        rn_r     <= rn_lat;
      end
    end
  end
endmodule

// File: tb/tb_fp_divsqrt_unit.sv
// Scoreboard bench for fp_divsqrt_unit: expected results are queued at issue
// and compared (value, rn, latency) when done pulses.
`timescale 1ns/1ps
module tb_fp_divsqrt_unit;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic clk = 1'b0;
  logic clrn;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rn;
    int          start_cyc;
  } exp_t;
  exp_t sb[$];

  fp_divsqrt_if bus();

  fp_divsqrt_unit dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!clrn && bus.done) begin
      if (sb.size() == 0) check("unexpected_done", 32'(bus.done), 32'd0);
      else begin
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("rn", 32'(bus.rn), 32'(e.rn));
        check("latency", 32'(cyc - e.start_cyc), 32'd28);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] fd,
                       input logic sq, input logic [31:0] exp_res, input bit push);
    int k;
    k = 0;
    while (bus.busy && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
    bus.a = a; bus.b = b; bus.fd = fd; bus.fsqrt = sq; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (push) sb.push_back('{exp_res, fd, cyc});
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_for_done();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    if (!bus.done) check("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic wait_done();
    wait_for_done();
    @(negedge clk);
    check("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] fd,
                        input logic sq, input logic [31:0] exp_res);
    issue(a, b, fd, sq, exp_res, 1'b1);
    wait_done();
  endtask

  task automatic pulse_ignored();
    bus.a = 32'h3F80_0000; bus.b = 32'h3F80_0000; bus.fd = 5'd9; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.fsqrt = 1'b0; bus.a = '0; bus.b = '0; bus.fd = '0;
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_rn", 32'(bus.rn), 32'd0);
    clrn = 1'b0;
    @(negedge clk);

    // Divide: normal values, rounding, specials, overflow.
    run_op(32'h40C0_0000, 32'h4000_0000, 5'd5, 1'b0, 32'h4040_0000);
    run_op(32'h3F80_0000, 32'h4040_0000, 5'd1, 1'b0, 32'h3EAA_AAAB);
    run_op(32'hBF80_0000, 32'h0000_0000, 5'd2, 1'b0, 32'hFF80_0000);
    run_op(32'h0000_0000, 32'h0000_0000, 5'd4, 1'b0, QNAN);
    run_op(32'h7F80_0000, 32'h7F80_0000, 5'd6, 1'b0, QNAN);
    run_op(32'h7F7F_FFFF, 32'h3F00_0000, 5'd7, 1'b0, 32'h7F80_0000);
    run_op(32'h3F80_0000, 32'h7F80_0000, 5'd8, 1'b0, 32'h0000_0000);
    run_op(32'h8000_0000, 32'h4000_0000, 5'd10, 1'b0, 32'h8000_0000);
    run_op(32'h7FC0_0001, 32'h3F80_0000, 5'd11, 1'b0, QNAN);
    run_op(32'hC0C0_0000, 32'h4000_0000, 5'd12, 1'b0, 32'hC040_0000);

    // Starts while busy (cycle 5, cycle 27, done cycle) are ignored.
    issue(32'h40C0_0000, 32'h4000_0000, 5'd3, 1'b0, 32'h4040_0000, 1'b1);
    repeat (4) @(negedge clk);
    pulse_ignored();
    repeat (21) @(negedge clk);
    pulse_ignored();
    wait_for_done();
    pulse_ignored();
    check("busy_after_ignored", 32'(bus.busy), 32'd0);
    // Back-to-back start the cycle after done.
    run_op(32'h3F80_0000, 32'h4040_0000, 5'd13, 1'b0, 32'h3EAA_AAAB);

    // Reset mid-operation aborts with no done pulse.
    issue(32'h40C0_0000, 32'h4000_0000, 5'd14, 1'b0, 32'h4040_0000, 1'b0);
    repeat (9) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", bus.result, 32'd0);
    check("abort_rn", 32'(bus.rn), 32'd0);
    clrn = 1'b0;
    repeat (40) @(negedge clk);

    // Square root select.
`ifdef FP_DIVSQRT_FSQRT_EN
    run_op(32'h4080_0000, 32'h0000_0000, 5'd15, 1'b1, 32'h4000_0000);
    run_op(32'hBF80_0000, 32'h0000_0000, 5'd16, 1'b1, QNAN);
`else
    run_op(32'h4080_0000, 32'h0000_0000, 5'd15, 1'b1, QNAN);
`endif

    repeat (40) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
